// File: rtl/npu_bus_master.sv
// ---------------------------------------------------------------------------
// npu_bus_master
//
// Bus master that pushes one NPU command at a time through a three-register
// window: it writes the activation type, writes the input operand, then reads
// the output word back. Each bus transfer has a one-cycle address phase and a
// data phase that the slave can stretch with ready_i=0. If the slave returns
// an error response, the remaining transfers are skipped and an error result
// is reported instead.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    command handshake; cmd_type_i, cmd_data_i payload
//   res_valid_o/ready_i    result handshake; res_data_o, res_err_o payload
//   sel_o, trans_o         slave select / transfer request (address phase)
//   write_o, addr_o        direction and address (address + data phase)
//   wdata_o                write data (write data phase only, else 0)
//   ready_o                bus ready to slave (mirrors ready_i)
//   rdata_i, resp_i        read data and error response from slave
//   ready_i                slave ready, ends a data phase
// ---------------------------------------------------------------------------
module npu_bus_master #(
  parameter int                DWidth    = 32,
  parameter logic [DWidth-1:0] BaseAddr  = 'h0,
  parameter logic [DWidth-1:0] TypeOff   = 'h0,
  parameter logic [DWidth-1:0] InputOff  = 'h4,
  parameter logic [DWidth-1:0] OutputOff = 'h8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // command side
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DWidth-1:0] cmd_type_i,
  input  logic [DWidth-1:0] cmd_data_i,
  // result side
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DWidth-1:0] res_data_o,
  output logic              res_err_o,
  // bus side
  output logic              sel_o,
  output logic              trans_o,
  output logic              write_o,
  output logic [DWidth-1:0] addr_o,
  output logic [DWidth-1:0] wdata_o,
  output logic              ready_o,
  input  logic [DWidth-1:0] rdata_i,
  input  logic              resp_i,
  input  logic              ready_i
);

  typedef enum logic [2:0] {
    IDLE,
    TYP_A,
    TYP_D,
    IN_A,
    IN_D,
    OUT_A,
    OUT_D,
    RESULT
  } state_t;

  // Sums are truncated to DWidth, so the window wraps modulo 2^DWidth.
  localparam logic [DWidth-1:0] TypeAddr = BaseAddr + TypeOff;
  localparam logic [DWidth-1:0] InAddr   = BaseAddr + InputOff;
  localparam logic [DWidth-1:0] OutAddr  = BaseAddr + OutputOff;

  state_t            r_state;
  logic [DWidth-1:0] r_cmdType;
  logic [DWidth-1:0] r_cmdData;
  logic              r_cmdReady;
  logic              r_sel;
  logic              r_trans;
  logic              r_write;
  logic [DWidth-1:0] r_addr;
  logic [DWidth-1:0] r_wdata;
  logic              r_resValid;
  logic [DWidth-1:0] r_resData;
  logic              r_resErr;

  logic w_dataPhase;
  logic w_busErr;

  assign w_dataPhase = (r_state == TYP_D) || (r_state == IN_D) || (r_state == OUT_D);
  // An error response only counts when it arrives with ready_i.
  assign w_busErr    = w_dataPhase && ready_i && resp_i;

  // All outputs are registered: every transition loads the output values of
  // the state being entered, so the bus signals line up with r_state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cmdType  <= '0;
      r_cmdData  <= '0;
      r_cmdReady <= 1'b0;
      r_sel      <= 1'b0;
      r_trans    <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resErr   <= 1'b0;
    end else if (w_busErr) begin
      // Abort: skip remaining transfers and report an error result.
      r_sel      <= 1'b0;
      r_trans    <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_resData  <= '0;
      r_resErr   <= 1'b1;
      r_resValid <= 1'b1;
      r_state    <= RESULT;
    end else begin
      unique case (r_state)
        IDLE: begin
          // cmd_ready_o rises one cycle after reset release or consumption.
          r_cmdReady <= 1'b1;
          if (cmd_valid_i && r_cmdReady) begin
            r_cmdType  <= cmd_type_i;
            r_cmdData  <= cmd_data_i;
            r_cmdReady <= 1'b0;
            r_resErr   <= 1'b0;
            r_sel      <= 1'b1;
            r_trans    <= 1'b1;
            r_write    <= 1'b1;
            r_addr     <= TypeAddr;
            r_wdata    <= '0;
            r_state    <= TYP_A;
          end
        end
        TYP_A: begin
          r_sel   <= 1'b0;
          r_trans <= 1'b0;
          r_wdata <= r_cmdType;
          r_state <= TYP_D;
        end
        TYP_D: begin
          if (ready_i) begin
            r_sel   <= 1'b1;
            r_trans <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= InAddr;
            r_wdata <= '0;
            r_state <= IN_A;
          end
        end
        IN_A: begin
          r_sel   <= 1'b0;
          r_trans <= 1'b0;
          r_wdata <= r_cmdData;
          r_state <= IN_D;
        end
        IN_D: begin
          if (ready_i) begin
            r_sel   <= 1'b1;
            r_trans <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= OutAddr;
            r_wdata <= '0;
            r_state <= OUT_A;
          end
        end
        OUT_A: begin
          r_sel   <= 1'b0;
          r_trans <= 1'b0;
          r_state <= OUT_D;
        end
        OUT_D: begin
          if (ready_i) begin
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_resData  <= rdata_i;
            r_resErr   <= 1'b0;
            r_resValid <= 1'b1;
            r_state    <= RESULT;
          end
        end
        RESULT: begin
          // cmd_ready_o stays low here, so a new command can never be taken
          // on the same edge that consumes the result.
          if (res_ready_i) begin
            r_resValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmdReady;
  assign res_valid_o = r_resValid;
  assign res_data_o  = r_resData;
  assign res_err_o   = r_resErr;
  assign sel_o       = r_sel;
  assign trans_o     = r_trans;
  assign write_o     = r_write;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign ready_o     = ready_i;

endmodule

// File: tb/tb_npu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_npu_bus_master
//
// Two instances share every input: uDutA uses the default window base and
// uDutB uses base 'h1000, so both address maps are exercised by the same
// traffic. The bench plays the bus slave and the command/result partner.
// Expected bus beats, latencies and results come from a transaction-level
// model: transfer list (type write, input write, output read), per-transfer
// wait counts and an optional error-response transfer index.
// ---------------------------------------------------------------------------
module tb_npu_bus_master;

  localparam logic [31:0] BaseA = 32'h0;
  localparam logic [31:0] BaseB = 32'h1000;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic [31:0] cmdType;
  logic [31:0] cmdData;
  logic        resReady;
  logic [31:0] rdataIn;
  logic        respIn;
  logic        readyIn;

  logic        aCmdReady, aResValid, aResErr, aSel, aTrans, aWrite, aReadyO;
  logic [31:0] aResData, aAddr, aWdata;
  logic        bCmdReady, bResValid, bResErr, bSel, bTrans, bWrite, bReadyO;
  logic [31:0] bResData, bAddr, bWdata;

  int checks   = 0;
  int failures = 0;

  npu_bus_master #(.DWidth(32)) uDutA (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValid), .cmd_ready_o(aCmdReady),
    .cmd_type_i(cmdType), .cmd_data_i(cmdData),
    .res_valid_o(aResValid), .res_ready_i(resReady),
    .res_data_o(aResData), .res_err_o(aResErr),
    .sel_o(aSel), .trans_o(aTrans), .write_o(aWrite),
    .addr_o(aAddr), .wdata_o(aWdata), .ready_o(aReadyO),
    .rdata_i(rdataIn), .resp_i(respIn), .ready_i(readyIn)
  );

  npu_bus_master #(.DWidth(32), .BaseAddr(32'h1000)) uDutB (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValid), .cmd_ready_o(bCmdReady),
    .cmd_type_i(cmdType), .cmd_data_i(cmdData),
    .res_valid_o(bResValid), .res_ready_i(resReady),
    .res_data_o(bResData), .res_err_o(bResErr),
    .sel_o(bSel), .trans_o(bTrans), .write_o(bWrite),
    .addr_o(bAddr), .wdata_o(bWdata), .ready_o(bReadyO),
    .rdata_i(rdataIn), .resp_i(respIn), .ready_i(readyIn)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZeroA(input string tag);
    checkOutput({tag, "Ctrl"},
                32'({aSel, aTrans, aWrite, aResValid, aResErr, aCmdReady}), 32'h0);
    checkOutput({tag, "Addr"}, aAddr, 32'h0);
    checkOutput({tag, "Wdata"}, aWdata, 32'h0);
    checkOutput({tag, "ResData"}, aResData, 32'h0);
  endtask

  // One full command: handshake, three bus transfers (or fewer on error),
  // result hold and consumption. errPhase is the transfer index (0..2) that
  // gets an error response, or -1 for none. keepValid leaves cmd_valid_i high
  // after acceptance; resetInOutD pulses reset in the output-read data phase.
  task automatic applyStimulus(input logic [31:0] typ, input logic [31:0] dat,
                               input logic [31:0] rd, input int w0, input int w1,
                               input int w2, input int errPhase, input int hold,
                               input bit keepValid, input bit resetInOutD);
    int          waits[3];
    logic [31:0] offs[3];
    logic [31:0] words[3];
    int          expLat;
    int          cycles;
    int          n;
    bit          aborted;
    bit          expErr;
    logic [31:0] expData;

    waits[0] = w0;    waits[1] = w1;    waits[2] = w2;
    offs[0]  = 32'h0; offs[1]  = 32'h4; offs[2]  = 32'h8;
    words[0] = typ;   words[1] = dat;   words[2] = 32'h0;

    // Reference: each executed transfer costs 2 cycles plus its waits.
    expLat  = 0;
    aborted = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (!aborted) begin
        expLat += 2 + waits[p];
        if (errPhase == p) aborted = 1'b1;
      end
    end
    expErr  = (errPhase >= 0) && (errPhase < 3);
    expData = expErr ? 32'h0 : rd;

    cmdValid = 1'b1;
    cmdType  = typ;
    cmdData  = dat;
    n = 0;
    while (!aCmdReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmdReadyWait", 32'(aCmdReady), 32'h1);
    checkOutput("cmdReadyB", 32'(bCmdReady), 32'h1);
    if (!aCmdReady) begin
      cmdValid = 1'b0;
      return;
    end

    @(negedge clk);
    cycles = 0;
    if (!keepValid) cmdValid = 1'b0;
    aborted = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (aborted) break;
      checkOutput($sformatf("addrSelTrans%0d", p), 32'({aSel, aTrans}), 32'h3);
      checkOutput($sformatf("addrWrite%0d", p), 32'(aWrite), 32'(p < 2));
      checkOutput($sformatf("addrA%0d", p), aAddr, BaseA + offs[p]);
      checkOutput($sformatf("addrB%0d", p), bAddr, BaseB + offs[p]);
      checkOutput($sformatf("addrWdata%0d", p), aWdata, 32'h0);
      checkOutput($sformatf("cmdReadyBusy%0d", p), 32'(aCmdReady), 32'h0);
      readyIn = 1'b0;
      respIn  = 1'b0;
      rdataIn = $urandom;
      for (int w = 0; w <= waits[p]; w++) begin
        @(negedge clk);
        cycles++;
        checkOutput($sformatf("dataSelTrans%0d", p), 32'({aSel, aTrans}), 32'h0);
        checkOutput($sformatf("dataWrite%0d", p), 32'(aWrite), 32'(p < 2));
        checkOutput($sformatf("dataAddr%0d", p), aAddr, BaseA + offs[p]);
        checkOutput($sformatf("dataWdata%0d", p), aWdata, words[p]);
        if (resetInOutD && p == 2) begin
          rstN = 1'b0;
          #1;
          checkAllZeroA("midReset");
          checkOutput("midResetB", 32'({bSel, bTrans, bResValid, bAddr != 0}), 32'h0);
          @(negedge clk);
          rstN     = 1'b1;
          cmdValid = 1'b0;
          readyIn  = 1'b0;
          respIn   = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("noResultAfterReset", 32'(aResValid), 32'h0);
          end
          checkOutput("cmdReadyAfterReset", 32'(aCmdReady), 32'h1);
          return;
        end
        if (w < waits[p]) begin
          readyIn = 1'b0;
        end else begin
          readyIn = 1'b1;
          respIn  = (errPhase == p);
          if (p == 2) rdataIn = rd;
          #1;
          checkOutput("readyPassthru", 32'(aReadyO), 32'h1);
        end
      end
      if (errPhase == p) aborted = 1'b1;
      @(negedge clk);
      cycles++;
      readyIn = 1'b0;
      respIn  = 1'b0;
      rdataIn = $urandom;
    end

    n = 0;
    while (!aResValid && n < 20) begin
      @(negedge clk);
      cycles++;
      n++;
    end
    checkOutput("latency", 32'(cycles), 32'(expLat));
    checkOutput("resValid", 32'(aResValid), 32'h1);
    checkOutput("resData", aResData, expData);
    checkOutput("resErr", 32'(aResErr), 32'(expErr));
    checkOutput("resBusIdle", 32'({aSel, aTrans}), 32'h0);
    checkOutput("resWdata", aWdata, 32'h0);
    checkOutput("resDataB", bResData, expData);

    for (int k = 0; k < hold; k++) begin
      resReady = 1'b0;
      rdataIn  = $urandom;
      @(negedge clk);
      checkOutput("holdValid", 32'(aResValid), 32'h1);
      checkOutput("holdData", aResData, expData);
      checkOutput("holdErr", 32'(aResErr), 32'(expErr));
    end
    resReady = 1'b1;
    checkOutput("cmdReadyAtConsume", 32'(aCmdReady), 32'h0);
    @(negedge clk);
    resReady = 1'b0;
    checkOutput("resValidCleared", 32'(aResValid), 32'h0);
    checkOutput("cmdReadyIdle", 32'(aCmdReady), 32'h1);
  endtask

  initial begin
    int errP;
    rstN     = 1'b1;
    cmdValid = 1'b0;
    cmdType  = 32'h0;
    cmdData  = 32'h0;
    resReady = 1'b0;
    rdataIn  = 32'h0;
    respIn   = 1'b0;
    readyIn  = 1'b0;
    #1 rstN = 1'b0;
    #2;
    $display("[TB] reset state");
    checkAllZeroA("reset");
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("cmdReadyAtRelease", 32'(aCmdReady), 32'h0);
    @(negedge clk);
    checkOutput("cmdReadyAfterRelease", 32'(aCmdReady), 32'h1);

    $display("[TB] nominal transaction");
    applyStimulus(32'h1, 32'h10, 32'h20, 0, 0, 0, -1, 0, 1'b0, 1'b0);
    $display("[TB] wait states in input write");
    applyStimulus(32'h1, 32'h10, 32'h20, 0, 3, 0, -1, 0, 1'b0, 1'b0);
    $display("[TB] error response on type write");
    applyStimulus(32'h2, 32'h33, 32'h44, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    $display("[TB] result held for 5 cycles");
    applyStimulus(32'h3, 32'h55, 32'hCAFE_F00D, 0, 0, 0, -1, 5, 1'b0, 1'b0);
    $display("[TB] reset during output read");
    applyStimulus(32'h4, 32'h66, 32'h77, 0, 0, 1, -1, 0, 1'b0, 1'b1);
    applyStimulus(32'h5, 32'h88, 32'h99, 0, 0, 0, -1, 0, 1'b0, 1'b0);
    $display("[TB] back-to-back commands");
    applyStimulus(32'h6, 32'hAA, 32'hBB, 0, 0, 0, -1, 1, 1'b1, 1'b0);
    applyStimulus(32'h7, 32'hCC, 32'hDD, 0, 0, 0, -1, 0, 1'b0, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      errP = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      applyStimulus($urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), errP,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end
    cmdValid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
